// File: rtl/register_dump_unit.sv
// Debug-side register dump engine: walks the register file's debug read port
// and streams every word MSB-first as bytes over a valid/ready interface.
module register_dump_unit #(
    parameter int NB_DATA        = 32,
    parameter int NB_REG_ADDRESS = 5,
    parameter int NB_BYTE        = 8,
    parameter int N_REGS         = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [NB_DATA-1:0]        i_dato_de_debug,
    output logic [NB_REG_ADDRESS-1:0] o_direc_de_lectura_de_debug,
    output logic [NB_BYTE-1:0]        o_tx_data,
    output logic                      o_tx_valid,
    input  logic                      i_tx_ready,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int N_BYTES  = NB_DATA / NB_BYTE;
    localparam int NB_COUNT = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [NB_COUNT-1:0]       LAST_BYTE = NB_COUNT'(N_BYTES - 1);
    localparam logic [NB_REG_ADDRESS-1:0] LAST_REG  = NB_REG_ADDRESS'(N_REGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        SEND,
        DONE
    } state_t;

    state_t                    state;
    logic [NB_REG_ADDRESS-1:0] reg_index;
    logic [NB_COUNT-1:0]       byte_count;
    logic [NB_DATA-1:0]        shift_reg;
    logic                      tx_valid;
    logic                      busy;
    logic                      done;
    logic                      transfer;

    assign transfer = tx_valid & i_tx_ready;

    // Valid, busy and done are registered alongside the state so every output
    // comes straight from a flop; the shift register empties itself to zero.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= IDLE;
            reg_index  <= '0;
            byte_count <= '0;
            shift_reg  <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (i_start) begin
                        reg_index <= '0;
                        busy      <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    shift_reg  <= i_dato_de_debug;
                    byte_count <= '0;
                    tx_valid   <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (transfer) begin
                        shift_reg <= shift_reg << NB_BYTE;
                        if (byte_count == LAST_BYTE) begin
                            tx_valid <= 1'b0;
                            if (reg_index == LAST_REG) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                reg_index <= reg_index + 1'b1;
                                state     <= ADDR;
                            end
                        end else begin
                            byte_count <= byte_count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outside ADDR the address simply keeps the last index; the sink ignores it.
    assign o_direc_de_lectura_de_debug = reg_index;
    assign o_tx_data                   = shift_reg[NB_DATA-1 -: NB_BYTE];
    assign o_tx_valid                  = tx_valid;
    assign o_busy                      = busy;
    assign o_done                      = done;

endmodule

// File: tb/tb_register_dump_unit.sv
// Randomized self-checking bench: a byte-stream scoreboard built from a register
// image predicts every accepted byte; a second instance covers the one-register dump.
module tb_register_dump_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dato;
    logic [4:0]  direc;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    logic        start1;
    logic [31:0] dato1;
    logic [4:0]  direc1;
    logic [7:0]  tx_data1;
    logic        tx_valid1;
    logic        tx_ready1;
    logic        busy1;
    logic        done1;

    logic [31:0] regs [32];
    logic [7:0]  exp_q [$];
    logic [7:0]  got [$];
    logic [7:0]  got1 [$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int ready_mode = 0;
    int stall_cnt  = 0;
    int start_cyc, first_valid_cyc, busy_cyc, done_cyc, done_count;
    logic       hold_pending = 1'b0;
    logic [7:0] held_data    = 8'h00;

    register_dump_unit dut (
        .i_clock                     (clk),
        .i_reset                     (rst),
        .i_start                     (start),
        .i_dato_de_debug             (dato),
        .o_direc_de_lectura_de_debug (direc),
        .o_tx_data                   (tx_data),
        .o_tx_valid                  (tx_valid),
        .i_tx_ready                  (tx_ready),
        .o_busy                      (busy),
        .o_done                      (done)
    );

    register_dump_unit #(.N_REGS(1)) dut1 (
        .i_clock                     (clk),
        .i_reset                     (rst),
        .i_start                     (start1),
        .i_dato_de_debug             (dato1),
        .o_direc_de_lectura_de_debug (direc1),
        .o_tx_data                   (tx_data1),
        .o_tx_valid                  (tx_valid1),
        .i_tx_ready                  (tx_ready1),
        .o_busy                      (busy1),
        .o_done                      (done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // The register file answers the debug read port combinationally.
    assign dato  = regs[direc];
    assign dato1 = 32'hDEAD_BEEF;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Sink readiness: 0 always ready, 1 random, 2 three-cycle stall on the second byte.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: tx_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (tx_valid && got.size() == 1 && stall_cnt < 3) begin
                    tx_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    tx_ready = 1'b1;
                end
            end
            default: tx_ready = 1'b1;
        endcase
    end

    // Compare process: every accepted byte against the scoreboard, plus the handshake rules.
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (busy && busy_cyc < 0) busy_cyc = cyc;
            if (hold_pending) begin
                check_output("valid_held", {31'd0, tx_valid}, 32'd1);
                check_output("data_held", {24'd0, tx_data}, {24'd0, held_data});
            end
            if (tx_valid || done) check_output("busy_active", {31'd0, busy}, 32'd1);
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL extra_byte: got 0x%0h, expected no byte", tx_data);
                end else begin
                    check_output("stream_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            hold_pending = tx_valid && !tx_ready;
            held_data    = tx_data;
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    // Build the expected stream from the current register image, MSB byte first.
    task automatic plan_run();
        got.delete();
        exp_q.delete();
        for (int k = 0; k < 32; k++)
            for (int b = 3; b >= 0; b--) exp_q.push_back(regs[k][8*b +: 8]);
        done_count      = 0;
        done_cyc        = -1;
        first_valid_cyc = -1;
        busy_cyc        = -1;
        stall_cnt       = 0;
    endtask

    task automatic apply_stimulus();
        @(posedge clk); #1;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_count == 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_count == 0) begin
            n_checks++;
            $display("[TB] FAIL done_timeout: got no o_done, expected one within %0d cycles", budget);
        end
        repeat (3) @(posedge clk);
        #1;
        check_output("idle_after_run", {31'd0, busy}, 32'd0);
        check_output("done_once", done_count, 32'd1);
        check_output("byte_total", got.size(), 32'd128);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] new4, old3;
        int n;
        rst = 1'b1; start = 1'b0; start1 = 1'b0; tx_ready = 1'b1; tx_ready1 = 1'b1;
        for (int k = 0; k < 32; k++) regs[k] = 32'hA0A0_0000 + k;
        done_count = 0; first_valid_cyc = -1; busy_cyc = -1; done_cyc = -1;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_direc", {27'd0, direc}, 32'd0);
        check_output("reset_tx_data", {24'd0, tx_data}, 32'd0);
        check_output("reset_valid", {31'd0, tx_valid}, 32'd0);
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        $display("[TB] full dump with sink always ready");
        ready_mode = 0;
        plan_run();
        apply_stimulus();
        wait_done(400);
        check_output("first_valid_latency", first_valid_cyc - start_cyc, 32'd2);
        check_output("dump_length", done_cyc - busy_cyc, 32'd160);
        if (got.size() == 128) begin
            check_output("pin_byte0", {24'd0, got[0]}, 32'hA0);
            check_output("pin_byte2", {24'd0, got[2]}, 32'h00);
            check_output("pin_byte7", {24'd0, got[7]}, 32'h01);
            check_output("pin_byte127", {24'd0, got[127]}, 32'h1F);
        end

        $display("[TB] backpressure on the second byte");
        for (int k = 0; k < 32; k++) regs[k] = $urandom();
        regs[0] = 32'h1122_3344;
        plan_run();
        ready_mode = 2;
        apply_stimulus();
        wait_done(600);
        check_output("stall_cycles", stall_cnt, 32'd3);
        if (got.size() >= 4) begin
            check_output("bp_byte0", {24'd0, got[0]}, 32'h11);
            check_output("bp_byte1", {24'd0, got[1]}, 32'h22);
            check_output("bp_byte2", {24'd0, got[2]}, 32'h33);
            check_output("bp_byte3", {24'd0, got[3]}, 32'h44);
        end

        $display("[TB] start pulses while busy are ignored");
        ready_mode = 0;
        for (int k = 0; k < 32; k++) regs[k] = $urandom();
        plan_run();
        apply_stimulus();
        for (int i = 2; i <= 50; i++) begin
            start = (i == 5 || i == 20 || i == 50);
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_done(400);

        $display("[TB] reset on the second byte of reg 7");
        ready_mode = 1;
        for (int k = 0; k < 32; k++) regs[k] = $urandom();
        plan_run();
        apply_stimulus();
        n = 0;
        while (!(got.size() == 29 && tx_valid) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("reached_reg7_byte1", got.size(), 32'd29);
        rst = 1'b1;
        @(posedge clk); #1;
        check_output("rst_valid", {31'd0, tx_valid}, 32'd0);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_direc", {27'd0, direc}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_no_done", done_count, 32'd0);
        check_output("rst_bytes_kept", got.size(), 32'd29);
        for (int k = 0; k < 32; k++) regs[k] = $urandom();
        plan_run();
        apply_stimulus();
        wait_done(1200);

        $display("[TB] register write after its address cycle");
        for (int k = 0; k < 32; k++) regs[k] = $urandom();
        old3 = regs[3];
        new4 = ~regs[4];
        plan_run();
        for (int b = 0; b < 4; b++) exp_q[16 + b] = new4[8*(3-b) +: 8];
        apply_stimulus();
        n = 0;
        while (got.size() < 13 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        regs[3] = ~old3;
        regs[4] = new4;
        wait_done(1200);

        $display("[TB] randomized dump with random backpressure and stray starts");
        for (int k = 0; k < 32; k++) regs[k] = $urandom();
        plan_run();
        apply_stimulus();
        for (int i = 0; i < 100; i++) begin
            start = ($urandom_range(0, 9) == 0) && busy;
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_done(1200);

        $display("[TB] single-register instance");
        ready_mode = 0;
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        begin
            int done1_count = 0;
            int done1_at = -1;
            int last_at = -1;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (tx_valid1 && tx_ready1) begin
                    got1.push_back(tx_data1);
                    last_at = i;
                end
                if (done1) begin
                    done1_count++;
                    done1_at = i;
                end
            end
            #1;
            check_output("n1_bytes", got1.size(), 32'd4);
            if (got1.size() == 4) begin
                check_output("n1_byte0", {24'd0, got1[0]}, 32'hDE);
                check_output("n1_byte1", {24'd0, got1[1]}, 32'hAD);
                check_output("n1_byte2", {24'd0, got1[2]}, 32'hBE);
                check_output("n1_byte3", {24'd0, got1[3]}, 32'hEF);
            end
            check_output("n1_done_once", done1_count, 32'd1);
            check_output("n1_done_after_last", done1_at - last_at, 32'd1);
            check_output("n1_idle", {31'd0, busy1}, 32'd0);
        end

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
